// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter and its FIFO.
// Holds the parity mode codes and the transmit FSM state encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 16x oversampling: sub-bit ticks per serial bit
    localparam int SUB_TICKS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered count/empty/full.
// Ports: clk, rst_n (async low), flush, wr/wr_data, rd/rd_data, count, empty, full.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CW-1:0]    count_next;

    // flush wins over both ports; full/empty are the registered flags
    assign wr_ok   = wr && !full && !flush;
    assign rd_ok   = rd && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (wr_ok && !rd_ok)
            count_next = count + 1'b1;
        else if (rd_ok && !wr_ok)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO + 16x baud divider + framing FSM.
// Ports: clk, reset (async low), data_in/buffer_write/buffer_reset in; serial_out, FIFO flags, fill_level, overflow, tx_busy out.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int CLK_DIV    = 27,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 buffer_write,
    input  logic                 buffer_reset,
    output logic                 serial_out,
    output logic                 buffer_data_present,
    output logic                 buffer_half_full,
    output logic                 buffer_full,
    output logic [CW-1:0]        fill_level,
    output logic                 overflow,
    output logic                 tx_busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [3:0]    SUB_LAST = 4'(SUB_TICKS - 1);

    tx_state_t            state;
    logic [DW-1:0]        div_cnt;
    logic [3:0]           sub_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tick;
    logic                 bit_end;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CW-1:0]        fifo_count;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush   (buffer_reset),
        .wr      (buffer_write),
        .wr_data (data_in),
        .rd      (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign buffer_data_present = !fifo_empty;
    assign buffer_full         = fifo_full;
    assign fill_level          = fifo_count;
    assign buffer_half_full    = (fifo_count >= CW'(FIFO_DEPTH / 2));

    // divider only runs inside a frame, so bit timing is anchored to the start edge
    assign tick    = (state != S_IDLE) && (div_cnt == DIV_MAX);
    assign bit_end = tick && (sub_cnt == SUB_LAST);

    // pop from IDLE, or chain straight into the next frame at the last stop bit
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) ||
                  ((state == S_STOP) && bit_end && (stop_cnt == STOP_LAST)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (state == S_IDLE || div_cnt == DIV_MAX)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // a write that finds the FIFO full is lost; flush clears and masks it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (buffer_reset)
            overflow <= 1'b0;
        else if (buffer_write && fifo_full)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            sub_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            if (tick)
                sub_cnt <= sub_cnt + 4'd1;
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= S_START;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                        shreg      <= head;
                        par_bit    <= (^head) ^ (PARITY == PAR_ODD);
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state      <= S_DATA;
                        serial_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                state      <= S_PARITY;
                                serial_out <= par_bit;
                            end else begin
                                state      <= S_STOP;
                                serial_out <= 1'b1;
                                stop_cnt   <= 1'b0;
                            end
                        end else begin
                            serial_out <= shreg[0];
                            shreg      <= shreg >> 1;
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state      <= S_STOP;
                        serial_out <= 1'b1;
                        stop_cnt   <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            if (!fifo_empty) begin
                                state      <= S_START;
                                serial_out <= 1'b0;
                                shreg      <= head;
                                par_bit    <= (^head) ^ (PARITY == PAR_ODD);
                            end else begin
                                state      <= S_IDLE;
                                serial_out <= 1'b1;
                                tx_busy    <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances cover 8N1, 8E1 and 8O2 framing.
// Inputs driven after negedge-sampled checks; one task per scenario.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       wr0 = 1'b0;
    logic       wr1 = 1'b0;
    logic       wr2 = 1'b0;
    logic       brst = 1'b0;

    logic       so0, dp0, hf0, bf0, ov0, busy0;
    logic [4:0] fl0;
    logic       so1, dp1, hf1, bf1, ov1, busy1;
    logic [2:0] fl1;
    logic       so2, dp2, hf2, bf2, ov2, busy2;
    logic [2:0] fl2;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_BITS (8), .FIFO_DEPTH (16), .CLK_DIV (1),
        .PARITY (0), .STOP_BITS (1)
    ) dut0 (
        .clk (clk), .reset (reset), .data_in (din),
        .buffer_write (wr0), .buffer_reset (brst),
        .serial_out (so0), .buffer_data_present (dp0),
        .buffer_half_full (hf0), .buffer_full (bf0),
        .fill_level (fl0), .overflow (ov0), .tx_busy (busy0)
    );

    uart_tx_fifo #(
        .DATA_BITS (8), .FIFO_DEPTH (4), .CLK_DIV (1),
        .PARITY (1), .STOP_BITS (1)
    ) dut1 (
        .clk (clk), .reset (reset), .data_in (din),
        .buffer_write (wr1), .buffer_reset (brst),
        .serial_out (so1), .buffer_data_present (dp1),
        .buffer_half_full (hf1), .buffer_full (bf1),
        .fill_level (fl1), .overflow (ov1), .tx_busy (busy1)
    );

    uart_tx_fifo #(
        .DATA_BITS (8), .FIFO_DEPTH (4), .CLK_DIV (1),
        .PARITY (2), .STOP_BITS (2)
    ) dut2 (
        .clk (clk), .reset (reset), .data_in (din),
        .buffer_write (wr2), .buffer_reset (brst),
        .serial_out (so2), .buffer_data_present (dp2),
        .buffer_half_full (hf2), .buffer_full (bf2),
        .fill_level (fl2), .overflow (ov2), .tx_busy (busy2)
    );

    // expected line level for bit idx of a frame: start, 8 data LSB first,
    // optional parity (1 even / 2 odd), then stop bits
    function automatic logic exp_bit(input logic [7:0] b, input int par,
                                     input int idx);
        if (idx == 0)
            return 1'b0;
        if (idx <= 8)
            return b[idx-1];
        if (idx == 9 && par != 0)
            return (^b) ^ (par == 2);
        return 1'b1;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({so0, so1, so2} !== 3'b111)
            $display("FAIL reset_line: got %b want 111", {so0, so1, so2});
        else n_pass++;
        n_checks++;
        if ({dp0, hf0, bf0, ov0, busy0, fl0} !== 10'd0)
            $display("FAIL reset_flags0: got %b want 0",
                     {dp0, hf0, bf0, ov0, busy0, fl0});
        else n_pass++;
        n_checks++;
        if ({dp1, hf1, bf1, ov1, busy1, fl1, dp2, hf2, bf2, ov2, busy2, fl2} !== 16'd0)
            $display("FAIL reset_flags12: got %b want 0",
                     {dp1, hf1, bf1, ov1, busy1, fl1, dp2, hf2, bf2, ov2, busy2, fl2});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic [15:0] seen;
        int busy_low;
        busy_low = 0;
        @(negedge clk);
        din = b;
        wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0;
        n_checks++;
        if ({dp0, fl0, so0, busy0} !== {1'b1, 5'd1, 1'b1, 1'b0})
            $display("FAIL frame_%0h_latency: got dp/fill/line/busy %b want 1_00001_1_0",
                     b, {dp0, fl0, so0, busy0});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy0, fl0} !== {1'b1, 5'd0})
            $display("FAIL frame_%0h_pop: got busy/fill %b want 1_00000", b, {busy0, fl0});
        else n_pass++;
        for (int c = 0; c < 160; c++) begin
            seen[c%16] = so0;
            if (busy0 !== 1'b1)
                busy_low++;
            if (c % 16 == 15) begin
                n_checks++;
                if (seen !== {16{exp_bit(b, 0, c/16)}})
                    $display("FAIL frame_%0h_bit%0d: got %b want %b",
                             b, c/16, seen, {16{exp_bit(b, 0, c/16)}});
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy_low !== 0)
            $display("FAIL frame_%0h_busy: got %0d low cycles want 0", b, busy_low);
        else n_pass++;
        n_checks++;
        if ({busy0, so0} !== 2'b01)
            $display("FAIL frame_%0h_end: got busy/line %b want 01", b, {busy0, so0});
        else n_pass++;
    endtask

    task automatic test_parity;
        logic [15:0] s1, s2;
        @(negedge clk);
        din = 8'h07;
        wr1 = 1'b1;
        wr2 = 1'b1;
        @(negedge clk);
        wr1 = 1'b0;
        wr2 = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 192; c++) begin
            s1[c%16] = so1;
            s2[c%16] = so2;
            if (c % 16 == 15) begin
                if (c < 176) begin
                    n_checks++;
                    if (s1 !== {16{exp_bit(8'h07, 1, c/16)}})
                        $display("FAIL even_bit%0d: got %b want %b",
                                 c/16, s1, {16{exp_bit(8'h07, 1, c/16)}});
                    else n_pass++;
                end
                n_checks++;
                if (s2 !== {16{exp_bit(8'h07, 2, c/16)}})
                    $display("FAIL odd2_bit%0d: got %b want %b",
                             c/16, s2, {16{exp_bit(8'h07, 2, c/16)}});
                else n_pass++;
            end
            if (c == 176) begin
                n_checks++;
                if ({busy1, so1, busy2} !== 3'b011)
                    $display("FAIL parity_len176: got busy1/line1/busy2 %b want 011",
                             {busy1, so1, busy2});
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({busy2, so2} !== 2'b01)
            $display("FAIL odd2_len192: got busy/line %b want 01", {busy2, so2});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] seen;
        int c;
        for (int t = 0; t < 2724; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                c = t - 2;
                if (c < 17 * 160) begin
                    seen[c%16] = so0;
                    if (c % 16 == 15) begin
                        n_checks++;
                        if (seen !== {16{exp_bit(8'(c/160), 0, (c%160)/16)}})
                            $display("FAIL b2b_byte%0h_bit%0d: got %b want %b",
                                     c/160, (c%160)/16, seen,
                                     {16{exp_bit(8'(c/160), 0, (c%160)/16)}});
                        else n_pass++;
                    end
                end else if (c == 17 * 160) begin
                    n_checks++;
                    if ({busy0, so0, fl0, dp0} !== {1'b0, 1'b1, 5'd0, 1'b0})
                        $display("FAIL b2b_drained: got busy/line/fill/dp %b want 0_1_00000_0",
                                 {busy0, so0, fl0, dp0});
                    else n_pass++;
                end
            end
            if (t == 8) begin
                n_checks++;
                if ({fl0, hf0} !== {5'd7, 1'b0})
                    $display("FAIL b2b_fill7: got fill/half %b want 00111_0", {fl0, hf0});
                else n_pass++;
            end
            if (t == 9) begin
                n_checks++;
                if ({fl0, hf0} !== {5'd8, 1'b1})
                    $display("FAIL b2b_fill8: got fill/half %b want 01000_1", {fl0, hf0});
                else n_pass++;
            end
            if (t == 17) begin
                n_checks++;
                if ({fl0, bf0, ov0} !== {5'd16, 1'b1, 1'b0})
                    $display("FAIL b2b_full: got fill/full/ovf %b want 10000_1_0",
                             {fl0, bf0, ov0});
                else n_pass++;
            end
            if (t == 18) begin
                n_checks++;
                if ({fl0, bf0, hf0, ov0} !== {5'd16, 1'b1, 1'b1, 1'b1})
                    $display("FAIL b2b_overflow: got fill/full/half/ovf %b want 10000_1_1_1",
                             {fl0, bf0, hf0, ov0});
                else n_pass++;
            end
            if (t < 18) begin
                wr0 = 1'b1;
                din = 8'(t);
            end else begin
                wr0 = 1'b0;
            end
        end
    endtask

    task automatic test_full_pop;
        int waited;
        @(negedge clk);
        brst = 1'b1;
        @(negedge clk);
        brst = 1'b0;
        n_checks++;
        if ({ov0, fl0} !== 6'd0)
            $display("FAIL flush_idle: got ovf/fill %b want 0_00000", {ov0, fl0});
        else n_pass++;
        for (int t = 0; t < 163; t++) begin
            @(negedge clk);
            if (t == 17) begin
                n_checks++;
                if ({fl0, bf0, ov0} !== {5'd16, 1'b1, 1'b0})
                    $display("FAIL fullpop_full: got fill/full/ovf %b want 10000_1_0",
                             {fl0, bf0, ov0});
                else n_pass++;
            end
            if (t == 161) begin
                n_checks++;
                if ({fl0, ov0, busy0, so0} !== {5'd16, 1'b0, 1'b1, 1'b1})
                    $display("FAIL fullpop_before: got fill/ovf/busy/line %b want 10000_0_1_1",
                             {fl0, ov0, busy0, so0});
                else n_pass++;
            end
            if (t == 162) begin
                n_checks++;
                if ({fl0, bf0, ov0, so0} !== {5'd15, 1'b0, 1'b1, 1'b0})
                    $display("FAIL fullpop_after: got fill/full/ovf/line %b want 01111_0_1_0",
                             {fl0, bf0, ov0, so0});
                else n_pass++;
            end
            if (t < 17) begin
                wr0 = 1'b1;
                din = 8'(8'hA0 + t);
            end else if (t == 161) begin
                wr0 = 1'b1;
                din = 8'hEE;
            end else begin
                wr0 = 1'b0;
            end
        end
        wr0 = 1'b0;
        waited = 0;
        while (busy0 !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (busy0 !== 1'b0)
            $display("FAIL fullpop_drain: got busy %b after %0d cycles want 0", busy0, waited);
        else n_pass++;
    endtask

    task automatic test_flush;
        for (int t = 0; t < 171; t++) begin
            @(negedge clk);
            if (t == 6) begin
                n_checks++;
                if ({fl0, ov0} !== {5'd5, 1'b1})
                    $display("FAIL flush_pre: got fill/ovf %b want 00101_1", {fl0, ov0});
                else n_pass++;
            end
            if (t == 21) begin
                n_checks++;
                if ({fl0, ov0, dp0, busy0} !== {5'd0, 1'b0, 1'b0, 1'b1})
                    $display("FAIL flush_post: got fill/ovf/dp/busy %b want 00000_0_0_1",
                             {fl0, ov0, dp0, busy0});
                else n_pass++;
            end
            if (t == 161) begin
                n_checks++;
                if (busy0 !== 1'b1)
                    $display("FAIL flush_frame_runs: got busy %b want 1", busy0);
                else n_pass++;
            end
            if (t == 162 || t == 170) begin
                n_checks++;
                if ({busy0, so0, fl0} !== {1'b0, 1'b1, 5'd0})
                    $display("FAIL flush_idle_t%0d: got busy/line/fill %b want 0_1_00000",
                             t, {busy0, so0, fl0});
                else n_pass++;
            end
            brst = 1'b0;
            wr0 = 1'b0;
            if (t < 6) begin
                wr0 = 1'b1;
                din = 8'(8'h30 + t);
            end else if (t == 20) begin
                brst = 1'b1;
                wr0 = 1'b1;
                din = 8'h99;
            end
        end
        brst = 1'b0;
        wr0 = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [7:0] seq [4] = '{8'hA3, 8'h01, 8'h02, 8'h03};
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (t == 55) begin
                n_checks++;
                if ({busy0, fl0, so0} !== {1'b1, 5'd3, 1'b0})
                    $display("FAIL areset_pre: got busy/fill/line %b want 1_00011_0",
                             {busy0, fl0, so0});
                else n_pass++;
                #2 reset = 1'b0;
                #1;
                n_checks++;
                if ({so0, busy0, dp0, hf0, bf0, ov0, fl0} !== {1'b1, 10'd0})
                    $display("FAIL areset_async: got line/busy/dp/half/full/ovf/fill %b want 1_0_0_0_0_0_00000",
                             {so0, busy0, dp0, hf0, bf0, ov0, fl0});
                else n_pass++;
                break;
            end
            wr0 = (t < 4);
            if (t < 4)
                din = seq[t];
        end
        wr0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy0, so0, fl0} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL areset_release: got busy/line/fill %b want 0_1_00000",
                     {busy0, so0, fl0});
        else n_pass++;
        test_single_frame(8'hA3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame(8'h55);
        test_parity();
        test_back_to_back();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised buffered UART transmitter, the next generation of the fixed 8-bit uart_tx6 used in the loopback top level. It accepts bytes from PicoBlaze or key2ascii logic into a configurable-depth FIFO and serialises them as configurable frames: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. It replaces the external en_16_x_baud strobe with an internal 16x baud divider and adds fill level and sticky overflow reporting.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..8
FIFO_DEPTH, 16, FIFO entries, power of 2, legal 4..64
CLK_DIV, 27, clk cycles per 16x baud tick (50 MHz / 115200 / 16), legal >= 1
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, legal 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
data_in  in  DATA_BITS  byte to enqueue
buffer_write  in  1  enqueue data_in this cycle
buffer_reset  in  1  synchronous FIFO flush, active-high
serial_out  out  1  UART TX line, idles high
buffer_data_present  out  1  FIFO non-empty
buffer_half_full  out  1  fill_level >= FIFO_DEPTH/2
buffer_full  out  1  fill_level == FIFO_DEPTH
fill_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored
overflow  out  1  sticky: a write was dropped
tx_busy  out  1  frame in progress (FSM not IDLE)

Behaviour:
- Reset (reset=0, async): serial_out=1, all other outputs 0, FIFO empty, FSM IDLE, divider and sub-bit counters 0.
- FIFO write: when buffer_write=1 and buffer_full=0, data_in is stored at the edge. When buffer_full=1 the write is dropped and overflow is set, even if a pop occurs in the same cycle.
- Simultaneous write and pop: fill_level is unchanged and both operations complete.
- Flags are registered and reflect fill_level after the edge.
- buffer_reset: at the edge, empties the FIFO and clears overflow. A frame already in progress completes. buffer_reset has priority over a same-cycle buffer_write, which is dropped without setting overflow.
- Baud divider: counts 0..CLK_DIV-1 and emits a 1-cycle tick at CLK_DIV-1. It is held at 0 in IDLE, so every bit lasts exactly 16*CLK_DIV clocks from frame start.
- FSM IDLE -> START: taken on the first edge with FSM in IDLE and buffer_data_present=1. The head entry is popped into the shift register and serial_out=0 from that edge.
- Latency: write on edge k -> data present after k -> start bit after k+1.
- Bit sequence: START, then DATA (DATA_BITS bits, LSB first, shift register right-shifted each bit).
- DATA -> PARITY when PARITY != 0, otherwise -> STOP.
- PARITY bit: even = XOR of the data bits; odd = its inverse.
- STOP: STOP_BITS bits of 1.
- Bit transitions occur on the 16th tick of each bit, tracked by a 4-bit sub-bit counter.
- End of STOP: if the FIFO is non-empty, go directly to START with a new pop (no idle gap). Otherwise go to IDLE with serial_out=1.
- tx_busy=1 in every state except IDLE.
- Reset mid-frame: line returns high immediately, FIFO contents are lost, and there is no partial-frame recovery.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * 16 * CLK_DIV clocks.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2) and FSM state encoding (IDLE, START, DATA, PARITY, STOP).
- Sub-module sync_fifo: parametrised by width and depth. Provides wr/rd/flush inputs and count, empty, full outputs. It is reused later by the matching RX block.

Test Plan:
- CLK_DIV=1 (bit = 16 clk), PARITY=0, STOP_BITS=1; write 0x55 -> serial_out 0,1,0,1,0,1,0,1,0,1, each bit 16 clk. Start bit appears 2 clk after write. tx_busy high for 160 clk, then IDLE.
- PARITY=1; write 0x07 -> parity bit 1. PARITY=2; write 0x07 -> parity bit 0. STOP_BITS=2 -> two 16-clk high bits, frame 192 clk.
- FIFO_DEPTH=16; 18 back-to-back writes 0x00..0x11 -> first entry popped immediately, 16 stored. Then fill_level=16, buffer_full=1, half_full=1, overflow=1. 0x11 is never transmitted; 0x00..0x10 go out back-to-back with no gaps.
- Write while buffer_full=1 in the same cycle as a frame-end pop -> write dropped, overflow=1, fill_level=15.
- Mid-frame buffer_reset with 5 entries stored -> fill_level=0 and overflow=0 next cycle; current frame completes and the FSM returns to IDLE.
- Assert reset low mid-DATA bit -> serial_out=1 and all flags 0 asynchronously. After release, a write of 0xA3 produces a clean frame.
